imem_fetch_resp: RTL

Responder end of the PC → instruction-memory interface. Accepts the fetch address `pc` and enable `insEn` from the PC stage and runs a req/ack handshake with a variable-latency instruction memory. Returns a registered instruction plus its PC to the IF/ID boundary. While a fetch is outstanding it raises a stall request to the stall controller, so the PC holds.

---
 rtl/imem_fetch_resp_pkg.sv | 23 ++
 rtl/imem_hold_buf.sv | 41 ++++
 rtl/imem_fetch_resp.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/imem_fetch_resp_pkg.sv
// imem_fetch_resp_pkg: definitions shared by the instruction-fetch responder.
//   - fetch_state_t : handshake FSM encodings (FETCH_IDLE/REQ/HOLD/DRAIN)
//   - RST_ENABLE    : active level of the synchronous reset
//   - ZERO_WORD     : all-zero data word, default NOP instruction
//   - DATA_W        : instruction / register data width
//   - INS_ADDR_W    : byte-address width of the fetch PC
//   - STALL_IFID    : index of the IF/ID freeze bit in the stall vector
package imem_fetch_resp_pkg;

  localparam logic RST_ENABLE = 1'b1;
  localparam int   DATA_W     = 32;
  localparam int   INS_ADDR_W = 32;
  localparam int   STALL_IFID = 1;
  localparam logic [DATA_W-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_REQ   = 2'd1,
    FETCH_HOLD  = 2'd2,
    FETCH_DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/imem_hold_buf.sv
// imem_hold_buf: one-entry {instruction, pc} skid register. Catches a word
// that memory returns while IF/ID is frozen so the memory side can retire.
// Ports:
//   clk, rst       clock, synchronous active-high reset (clears full only)
//   load           capture load_ins/load_pc, set full
//   clear          drop the entry (clear wins over load)
//   load_ins/pc    word and byte address to capture
//   full           entry holds a valid word
//   ins, pc        stored word and byte address
module imem_hold_buf
  import imem_fetch_resp_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  clear,
  input  logic [DATA_W-1:0]     load_ins,
  input  logic [INS_ADDR_W-1:0] load_pc,
  output logic                  full,
  output logic [DATA_W-1:0]     ins,
  output logic [INS_ADDR_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      full <= 1'b0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      ins <= load_ins;
      pc  <= load_pc;
    end
  end

endmodule

// File: rtl/imem_fetch_resp.sv
// imem_fetch_resp: responder end of the PC -> instruction-memory path.
// Captures pc when insEn is set, runs a req/ack handshake with a
// variable-latency memory and returns a registered instruction and its pc
// to IF/ID. While a fetch is outstanding it requests a pipeline stall.
// Optional feature macro: IMEM_ALIGN_CHECK_EN (adds ins_misalign and
// suppresses memory requests for pcs with pc[1:0] != 0).
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   pc, insEn              fetch byte address and enable from PC stage
//   stall[5:0]             stall vector; stall[1] freezes IF/ID
//   flush                  drop the current and any outstanding fetch
//   mem_req, mem_addr      memory request (held until ack), word address
//   mem_ack, mem_rdata     one-cycle acknowledge with instruction word
//   ins, ins_pc, ins_valid registered instruction to IF/ID
//   stallreq_if            combinational stall request
//   ins_misalign           (feature only) misaligned pc presented
module imem_fetch_resp
  import imem_fetch_resp_pkg::*;
#(
  parameter int                AW       = 16,
  parameter logic [DATA_W-1:0] NOP_WORD = ZERO_WORD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INS_ADDR_W-1:0] pc,
  input  logic                  insEn,
  input  logic [5:0]            stall,
  input  logic                  flush,
  output logic                  mem_req,
  output logic [AW-1:0]         mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [DATA_W-1:0]     ins,
  output logic [INS_ADDR_W-1:0] ins_pc,
  output logic                  ins_valid,
  output logic                  stallreq_if
`ifdef IMEM_ALIGN_CHECK_EN
  ,
  output logic                  ins_misalign
`endif
);

  fetch_state_t          state_p0;
  logic [INS_ADDR_W-1:0] req_pc_p0;
  logic                  stall_ifid;
  logic                  hb_load, hb_clear, hb_full;
  logic [DATA_W-1:0]     hb_ins;
  logic [INS_ADDR_W-1:0] hb_pc;
  logic                  new_vld;
  logic [DATA_W-1:0]     new_ins;
  logic [INS_ADDR_W-1:0] new_pc;
  logic                  capture, cap_mis, cap_req;
  logic                  unused_bits;

  assign stall_ifid  = stall[STALL_IFID];
  // Remaining stall bits belong to later stages; pc bits outside the word
  // address never reach memory.
  assign unused_bits = ^{stall[5:2], stall[0], req_pc_p0[INS_ADDR_W-1:AW+2], req_pc_p0[1:0]};

`ifdef IMEM_ALIGN_CHECK_EN
  logic                  mis_pend, mis_present;
  logic [INS_ADDR_W-1:0] mis_pc;
  assign cap_mis     = capture && (pc[1:0] != 2'b00);
  assign mis_present = mis_pend && (state_p0 == FETCH_IDLE) && !stall_ifid && !flush;
`else
  logic mis_pend;
  assign mis_pend = 1'b0;
  assign cap_mis  = 1'b0;
`endif

  assign mem_addr = req_pc_p0[AW+1:2];

  always_comb begin
    mem_req     = 1'b0;
    stallreq_if = 1'b0;
    case (state_p0)
      // Drop the stall on the ack cycle so the PC advances on the same edge
      // that captures the data.
      FETCH_REQ: begin
        mem_req     = 1'b1;
        stallreq_if = ~mem_ack;
      end
      FETCH_HOLD:  stallreq_if = 1'b1;
      // Redirected PC must load while the stale fetch drains.
      FETCH_DRAIN: mem_req = 1'b1;
      default: ;
    endcase
  end

  // A new instruction reaches IF/ID only when IF/ID is not frozen.
  assign new_vld = !flush && !stall_ifid &&
                   (((state_p0 == FETCH_REQ) && mem_ack) ||
                    ((state_p0 == FETCH_HOLD) && hb_full));
  assign new_ins = (state_p0 == FETCH_HOLD) ? hb_ins : mem_rdata;
  assign new_pc  = (state_p0 == FETCH_HOLD) ? hb_pc  : req_pc_p0;
  assign capture = !flush && insEn &&
                   (((state_p0 == FETCH_IDLE) && !mis_pend) || new_vld);
  assign cap_req = capture && !cap_mis;

  assign hb_load  = (state_p0 == FETCH_REQ) && mem_ack && !flush && stall_ifid;
  assign hb_clear = flush || ((state_p0 == FETCH_HOLD) && !stall_ifid);

  imem_hold_buf u_hold_buf (
    .clk      (clk),
    .rst      (rst),
    .load     (hb_load),
    .clear    (hb_clear),
    .load_ins (mem_rdata),
    .load_pc  (req_pc_p0),
    .full     (hb_full),
    .ins      (hb_ins),
    .pc       (hb_pc)
  );

  // ---- stage p0 -> IF/ID: handshake FSM and output register ----
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_p0  <= FETCH_IDLE;
      req_pc_p0 <= '0;
      ins       <= NOP_WORD;
      ins_pc    <= '0;
      ins_valid <= 1'b0;
    end else if (flush) begin
      ins       <= NOP_WORD;
      ins_valid <= 1'b0;
      // A request still in flight must be retired before going idle.
      if (((state_p0 == FETCH_REQ) || (state_p0 == FETCH_DRAIN)) && !mem_ack)
        state_p0 <= FETCH_DRAIN;
      else
        state_p0 <= FETCH_IDLE;
    end else begin
      if (!stall_ifid) begin
        if (new_vld) begin
          ins       <= new_ins;
          ins_pc    <= new_pc;
          ins_valid <= 1'b1;
        end else begin
          ins       <= NOP_WORD;
          ins_valid <= 1'b0;
        end
      end
`ifdef IMEM_ALIGN_CHECK_EN
      if (mis_present) ins_pc <= mis_pc;
`endif
      if (cap_req) req_pc_p0 <= pc;
      case (state_p0)
        FETCH_IDLE:  if (cap_req) state_p0 <= FETCH_REQ;
        FETCH_REQ: begin
          if (mem_ack) begin
            if (stall_ifid) state_p0 <= FETCH_HOLD;
            else            state_p0 <= cap_req ? FETCH_REQ : FETCH_IDLE;
          end
        end
        FETCH_HOLD:  if (!stall_ifid) state_p0 <= cap_req ? FETCH_REQ : FETCH_IDLE;
        FETCH_DRAIN: if (mem_ack) state_p0 <= FETCH_IDLE;
        default:     state_p0 <= FETCH_IDLE;
      endcase
    end
  end

`ifdef IMEM_ALIGN_CHECK_EN
  // ---- misaligned pc: skip memory, flag it for one IF/ID cycle ----
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      mis_pend     <= 1'b0;
      ins_misalign <= 1'b0;
    end else if (flush) begin
      mis_pend     <= 1'b0;
      ins_misalign <= 1'b0;
    end else begin
      if (!stall_ifid) ins_misalign <= mis_present;
      if (mis_present) mis_pend <= 1'b0;
      if (cap_mis) begin
        mis_pend <= 1'b1;
        mis_pc   <= pc;
      end
    end
  end
`endif

endmodule
